// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the inst/data memory port arbiter: FSM states, owner encoding and
// the saturating starvation counter helper.
package mem_port_arbiter_pkg;

   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } state_e;

   typedef enum logic {
      OwnInst = 1'b0,
      OwnData = 1'b1
   } owner_e;

   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt,
                                                   input logic [STARVE_W-1:0] lim);
      return (cnt >= lim) ? lim : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by instruction fetch and data access, with fixed
// data priority, an anti-starvation counter for fetch and flush-based fetch cancellation.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req_valid,
   input  logic [ADDR_W-1:0]   inst_req_addr,
   output logic                inst_req_allowin,
   input  logic                inst_flush,
   output logic                inst_rsp_valid,
   output logic [DATA_W-1:0]   inst_rsp_rdata,
   input  logic                data_req_valid,
   input  logic                data_req_wr,
   input  logic [ADDR_W-1:0]   data_req_addr,
   input  logic [DATA_W-1:0]   data_req_wdata,
   input  logic [DATA_W/8-1:0] data_req_wstrb,
   output logic                data_req_allowin,
   output logic                data_rsp_valid,
   output logic [DATA_W-1:0]   data_rsp_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_wr,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_rdata
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                cancel_q, cancel_d;
   req_t                req_q, req_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                inst_rsp_valid_q, inst_rsp_valid_d;
   logic                data_rsp_valid_q, data_rsp_valid_d;
   logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

   logic idle;
   logic starved;
   logic inst_grant;
   logic data_grant;

   // Gating with rst keeps the allowins low while reset is held.
   assign idle    = rst & (state_q == StIdle);
   assign starved = (starve_q == STARVE_W'(STARVE_MAX));

   assign data_req_allowin = idle & ~(inst_req_valid & ~inst_flush & starved);
   assign inst_req_allowin = idle & ~inst_flush & (~data_req_valid | starved);
   assign data_grant       = data_req_valid & data_req_allowin;
   assign inst_grant       = inst_req_valid & inst_req_allowin;

   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      cancel_d         = cancel_q;
      req_d            = req_q;
      starve_d         = starve_q;
      inst_rsp_valid_d = 1'b0;
      data_rsp_valid_d = 1'b0;
      inst_rdata_d     = inst_rdata_q;
      data_rdata_d     = data_rdata_q;

      if ((state_q != StIdle) && (owner_q == OwnInst) && inst_flush) begin
         cancel_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (data_grant) begin
               state_d  = StReq;
               owner_d  = OwnData;
               cancel_d = 1'b0;
               req_d    = '{wr: data_req_wr, addr: data_req_addr, wdata: data_req_wdata,
                            wstrb: data_req_wstrb};
               if (inst_req_valid) begin
                  starve_d = sat_inc(starve_q, STARVE_W'(STARVE_MAX));
               end
            end else if (inst_grant) begin
               state_d  = StReq;
               owner_d  = OwnInst;
               cancel_d = 1'b0;
               req_d    = '{wr: 1'b0, addr: inst_req_addr, wdata: '0, wstrb: '0};
               starve_d = '0;
            end
         end
         StReq: begin
            if (mem_req_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mem_rsp_valid) begin
               state_d  = StIdle;
               cancel_d = 1'b0;
               if (owner_q == OwnData) begin
                  data_rsp_valid_d = 1'b1;
                  data_rdata_d     = req_q.wr ? '0 : mem_rsp_rdata;
               end else if (!cancel_q && !inst_flush) begin
                  inst_rsp_valid_d = 1'b1;
                  inst_rdata_d     = mem_rsp_rdata;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= StIdle;
         owner_q          <= OwnInst;
         cancel_q         <= 1'b0;
         req_q            <= '0;
         starve_q         <= '0;
         inst_rsp_valid_q <= 1'b0;
         data_rsp_valid_q <= 1'b0;
         inst_rdata_q     <= '0;
         data_rdata_q     <= '0;
      end else begin
         state_q          <= state_d;
         owner_q          <= owner_d;
         cancel_q         <= cancel_d;
         req_q            <= req_d;
         starve_q         <= starve_d;
         inst_rsp_valid_q <= inst_rsp_valid_d;
         data_rsp_valid_q <= data_rsp_valid_d;
         inst_rdata_q     <= inst_rdata_d;
         data_rdata_q     <= data_rdata_d;
      end
   end

   assign mem_req_valid  = (state_q == StReq);
   assign mem_req_wr     = req_q.wr;
   assign mem_req_addr   = req_q.addr;
   assign mem_req_wdata  = req_q.wdata;
   assign mem_req_wstrb  = req_q.wstrb;
   assign inst_rsp_valid = inst_rsp_valid_q;
   assign inst_rsp_rdata = inst_rdata_q;
   assign data_rsp_valid = data_rsp_valid_q;
   assign data_rsp_rdata = data_rdata_q;

`ifndef SYNTHESIS
   rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
      mem_rsp_valid |-> (state_q == StWait));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: idle acceptance table, directed multi-cycle sequences and a
// randomized run against a transaction-level reference model with a memory array.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req_valid = 1'b0;
   logic [31:0] inst_req_addr = '0;
   logic        inst_req_allowin;
   logic        inst_flush = 1'b0;
   logic        inst_rsp_valid;
   logic [31:0] inst_rsp_rdata;
   logic        data_req_valid = 1'b0;
   logic        data_req_wr = 1'b0;
   logic [31:0] data_req_addr = '0;
   logic [31:0] data_req_wdata = '0;
   logic [3:0]  data_req_wstrb = '0;
   logic        data_req_allowin;
   logic        data_rsp_valid;
   logic [31:0] data_rsp_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_wr;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;

   mem_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_req_valid  (inst_req_valid),
      .inst_req_addr   (inst_req_addr),
      .inst_req_allowin(inst_req_allowin),
      .inst_flush      (inst_flush),
      .inst_rsp_valid  (inst_rsp_valid),
      .inst_rsp_rdata  (inst_rsp_rdata),
      .data_req_valid  (data_req_valid),
      .data_req_wr     (data_req_wr),
      .data_req_addr   (data_req_addr),
      .data_req_wdata  (data_req_wdata),
      .data_req_wstrb  (data_req_wstrb),
      .data_req_allowin(data_req_allowin),
      .data_rsp_valid  (data_rsp_valid),
      .data_rsp_rdata  (data_rsp_rdata),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_wr      (mem_req_wr),
      .mem_req_addr    (mem_req_addr),
      .mem_req_wdata   (mem_req_wdata),
      .mem_req_wstrb   (mem_req_wstrb),
      .mem_rsp_valid   (mem_rsp_valid),
      .mem_rsp_rdata   (mem_rsp_rdata)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic iv;
      logic dv;
      logic fl;
      logic sat;
      logic ia;
      logic da;
   } vec_t;

   vec_t vecs [9];

   // Reference model state: one outstanding transaction plus the memory contents.
   logic [31:0] mem [logic [31:0]];
   bit          m_busy, m_sent, m_cancel, m_own_data, m_wr;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   int          m_starve, rsp_wait;
   bit          e_ipulse, e_dpulse;
   logic [31:0] e_irdata, e_drdata;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic adv();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk32({tag, "_ctl"}, 32'({inst_req_allowin, inst_rsp_valid, data_req_allowin,
                                data_rsp_valid, mem_req_valid, mem_req_wr, mem_req_wstrb}),
            32'h0);
      chk32({tag, "_mem_addr"}, mem_req_addr, 32'h0);
      chk32({tag, "_mem_wdata"}, mem_req_wdata, 32'h0);
      chk32({tag, "_inst_rdata"}, inst_rsp_rdata, 32'h0);
      chk32({tag, "_data_rdata"}, data_rsp_rdata, 32'h0);
   endtask

   // Idle-state acceptance table; valids are dropped before each edge so nothing is granted.
   task automatic apply_table(input logic sat);
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].sat == sat) begin
            adv();
            inst_req_valid = vecs[i].iv;
            data_req_valid = vecs[i].dv;
            inst_flush     = vecs[i].fl;
            #1;
            chk1($sformatf("tbl%0d_inst_allowin", i), inst_req_allowin, vecs[i].ia);
            chk1($sformatf("tbl%0d_data_allowin", i), data_req_allowin, vecs[i].da);
            inst_req_valid = 1'b0;
            data_req_valid = 1'b0;
            inst_flush     = 1'b0;
         end
      end
   endtask

   // Entered in the cycle after a grant; returns settled in the cycle after the response.
   task automatic mem_serve(input string tag, input int rdy_dly, input int rsp_dly,
                            input logic [31:0] rdata, input bit flush_wait);
      logic [31:0] a, d;
      for (int k = 0; k < 8 && !mem_req_valid; k++) adv();
      chk1({tag, "_req_valid"}, mem_req_valid, 1'b1);
      a = mem_req_addr;
      d = mem_req_wdata;
      mem_req_ready = 1'b0;
      for (int k = 0; k < rdy_dly; k++) begin
         #1;
         chk32({tag, "_hold_ctl"},
               32'({mem_req_valid, inst_req_allowin, data_req_allowin}), 32'h4);
         chk32({tag, "_hold_addr"}, mem_req_addr, a);
         chk32({tag, "_hold_wdata"}, mem_req_wdata, d);
         adv();
      end
      mem_req_ready = 1'b1;
      adv();
      mem_req_ready = 1'b0;
      #1;
      chk1({tag, "_req_drop"}, mem_req_valid, 1'b0);
      inst_flush = flush_wait;
      for (int k = 0; k < rsp_dly; k++) begin
         adv();
         inst_flush = 1'b0;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      adv();
      mem_rsp_valid = 1'b0;
      inst_flush    = 1'b0;
      #1;
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
   endfunction

   task automatic inst_fetch(input string tag, input logic [31:0] addr, input int rsp_dly,
                             input logic [31:0] rdata, input bit flush_wait);
      inst_req_valid = 1'b1;
      inst_req_addr  = addr;
      #1;
      chk1({tag, "_allowin"}, inst_req_allowin, 1'b1);
      adv();
      inst_req_valid = 1'b0;
      #1;
      chk32({tag, "_addr"}, mem_req_addr, addr);
      chk32({tag, "_wr_strb"}, 32'({mem_req_wr, mem_req_wstrb}), 32'h0);
      mem_serve(tag, 0, rsp_dly, rdata, flush_wait);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          exp_inst, idle, sat, e_ia, e_da;
      logic [31:0] v;

      vecs[0] = '{iv: 1'b0, dv: 1'b0, fl: 1'b0, sat: 1'b0, ia: 1'b1, da: 1'b1};
      vecs[1] = '{iv: 1'b1, dv: 1'b0, fl: 1'b0, sat: 1'b0, ia: 1'b1, da: 1'b1};
      vecs[2] = '{iv: 1'b0, dv: 1'b1, fl: 1'b0, sat: 1'b0, ia: 1'b0, da: 1'b1};
      vecs[3] = '{iv: 1'b1, dv: 1'b1, fl: 1'b0, sat: 1'b0, ia: 1'b0, da: 1'b1};
      vecs[4] = '{iv: 1'b1, dv: 1'b0, fl: 1'b1, sat: 1'b0, ia: 1'b0, da: 1'b1};
      vecs[5] = '{iv: 1'b1, dv: 1'b1, fl: 1'b0, sat: 1'b1, ia: 1'b1, da: 1'b0};
      vecs[6] = '{iv: 1'b1, dv: 1'b1, fl: 1'b1, sat: 1'b1, ia: 1'b0, da: 1'b1};
      vecs[7] = '{iv: 1'b0, dv: 1'b1, fl: 1'b0, sat: 1'b1, ia: 1'b1, da: 1'b1};
      vecs[8] = '{iv: 1'b1, dv: 1'b0, fl: 1'b0, sat: 1'b1, ia: 1'b1, da: 1'b0};

      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      #1;
      apply_table(1'b0);

      // Inst-only fetch.
      adv();
      inst_fetch("s1", 32'h1000_0000, 1, 32'hDEAD_BEEF, 1'b0);
      chk1("s1_inst_rsp", inst_rsp_valid, 1'b1);
      chk32("s1_inst_rdata", inst_rsp_rdata, 32'hDEAD_BEEF);
      chk1("s1_data_silent", data_rsp_valid, 1'b0);
      adv();
      chk1("s1_pulse_end", inst_rsp_valid, 1'b0);
      chk32("s1_rdata_held", inst_rsp_rdata, 32'hDEAD_BEEF);

      // Simultaneous requests: data store first, then the waiting fetch.
      inst_req_valid = 1'b1;
      inst_req_addr  = 32'h2000_0000;
      data_req_valid = 1'b1;
      data_req_wr    = 1'b1;
      data_req_addr  = 32'h20;
      data_req_wdata = 32'h55AA;
      data_req_wstrb = 4'h3;
      #1;
      chk1("s2_data_allowin", data_req_allowin, 1'b1);
      chk1("s2_inst_blocked", inst_req_allowin, 1'b0);
      adv();
      data_req_valid = 1'b0;
      #1;
      chk32("s2_store", 32'({mem_req_wr, mem_req_wstrb}), 32'h13);
      chk32("s2_store_addr", mem_req_addr, 32'h20);
      chk32("s2_store_wdata", mem_req_wdata, 32'h55AA);
      mem_serve("s2", 0, 0, 32'hFFFF_FFFF, 1'b0);
      chk1("s2_data_rsp", data_rsp_valid, 1'b1);
      chk32("s2_store_rdata", data_rsp_rdata, 32'h0);
      chk1("s2_inst_allowin", inst_req_allowin, 1'b1);
      adv();
      inst_req_valid = 1'b0;
      #1;
      chk32("s2_inst_addr", mem_req_addr, 32'h2000_0000);
      mem_serve("s2i", 0, 0, 32'h0000_2222, 1'b0);
      chk1("s2_inst_rsp", inst_rsp_valid, 1'b1);

      // Starvation: four data grants, then inst, then data again.
      inst_req_valid = 1'b1;
      inst_req_addr  = 32'h3000;
      data_req_valid = 1'b1;
      data_req_wr    = 1'b0;
      data_req_addr  = 32'h40;
      data_req_wstrb = 4'hF;
      #1;
      for (int g = 0; g < 6; g++) begin
         exp_inst = (g == 4);
         if (g == 4) begin
            inst_req_valid = 1'b0;
            data_req_valid = 1'b0;
            apply_table(1'b1);
            adv();
            inst_req_valid = 1'b1;
            data_req_valid = 1'b1;
            #1;
         end
         chk1($sformatf("s3_g%0d_inst_allowin", g), inst_req_allowin, exp_inst);
         chk1($sformatf("s3_g%0d_data_allowin", g), data_req_allowin, !exp_inst);
         adv();
         #1;
         chk32($sformatf("s3_g%0d_addr", g), mem_req_addr, exp_inst ? 32'h3000 : 32'h40);
         if (g == 5) begin
            inst_req_valid = 1'b0;
            data_req_valid = 1'b0;
         end
         mem_serve("s3", 0, 0, 32'(g), 1'b0);
         chk1($sformatf("s3_g%0d_rsp", g), exp_inst ? inst_rsp_valid : data_rsp_valid, 1'b1);
         chk32($sformatf("s3_g%0d_rdata", g), exp_inst ? inst_rsp_rdata : data_rsp_rdata,
               32'(g));
      end

      // Flush during WAIT, then a clean fetch, then a flush coinciding with the response.
      inst_fetch("s4", 32'h4000, 1, 32'h1234_5678, 1'b1);
      chk1("s4_cancelled", inst_rsp_valid, 1'b0);
      chk32("s4_rdata_held", inst_rsp_rdata, 32'h4);
      inst_fetch("s4b", 32'h4004, 0, 32'hCAFE_F00D, 1'b0);
      chk1("s4b_rsp", inst_rsp_valid, 1'b1);
      chk32("s4b_rdata", inst_rsp_rdata, 32'hCAFE_F00D);
      inst_fetch("s4c", 32'h4008, 0, 32'h7777_7777, 1'b1);
      chk1("s4c_cancelled", inst_rsp_valid, 1'b0);
      chk32("s4c_rdata_held", inst_rsp_rdata, 32'hCAFE_F00D);

      // Backpressure on a data load; a flush must not affect it.
      data_req_valid = 1'b1;
      data_req_addr  = 32'h80;
      data_req_wdata = 32'h0;
      #1;
      adv();
      data_req_valid = 1'b0;
      #1;
      mem_serve("s5", 5, 0, 32'h0BAD_CAFE, 1'b1);
      chk1("s5_data_rsp", data_rsp_valid, 1'b1);
      chk32("s5_rdata", data_rsp_rdata, 32'h0BAD_CAFE);

      // Asynchronous reset in WAIT, then a fresh fetch.
      inst_req_valid = 1'b1;
      inst_req_addr  = 32'h5000;
      #1;
      adv();
      inst_req_valid = 1'b0;
      mem_req_ready  = 1'b1;
      adv();
      mem_req_ready = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk_all_zero("s6_rst");
      adv();
      adv();
      rst = 1'b1;
      #1;
      inst_fetch("s6", 32'h1000_0000, 1, 32'hDEAD_BEEF, 1'b0);
      chk1("s6_rsp", inst_rsp_valid, 1'b1);
      chk32("s6_rdata", inst_rsp_rdata, 32'hDEAD_BEEF);

      // Randomized run against the reference model.
      rst = 1'b0;
      adv();
      rst = 1'b1;
      m_busy = 0; m_sent = 0; m_cancel = 0; m_own_data = 0; m_wr = 0;
      m_starve = 0; rsp_wait = 0;
      e_ipulse = 0; e_dpulse = 0; e_irdata = '0; e_drdata = '0;
      m_addr = '0; m_wdata = '0; m_wstrb = '0;
      for (int c = 0; c < 3000; c++) begin
         adv();
         inst_req_valid = ($urandom_range(0, 99) < 60);
         inst_req_addr  = 32'($urandom_range(0, 7)) << 2;
         inst_flush     = ($urandom_range(0, 99) < 10);
         data_req_valid = ($urandom_range(0, 99) < 50);
         data_req_wr    = 1'($urandom_range(0, 1));
         data_req_addr  = 32'($urandom_range(0, 7)) << 2;
         data_req_wdata = $urandom;
         data_req_wstrb = 4'($urandom_range(0, 15));
         mem_req_ready  = ($urandom_range(0, 99) < 50);
         mem_rsp_valid  = 1'b0;
         if (m_busy && m_sent && rsp_wait == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = m_wr ? $urandom : mem_rd(m_addr);
         end
         #1;
         idle = !m_busy;
         sat  = (m_starve == STARVE_MAX);
         e_ia = idle && !inst_flush && (!data_req_valid || sat);
         e_da = idle && !(inst_req_valid && !inst_flush && sat);
         chk1("rnd_inst_allowin", inst_req_allowin, e_ia);
         chk1("rnd_data_allowin", data_req_allowin, e_da);
         chk1("rnd_mem_req_valid", mem_req_valid, m_busy && !m_sent);
         if (m_busy && !m_sent) begin
            chk32("rnd_mem_addr", mem_req_addr, m_addr);
            chk32("rnd_mem_wr_strb", 32'({mem_req_wr, mem_req_wstrb}), 32'({m_wr, m_wstrb}));
            if (m_wr) chk32("rnd_mem_wdata", mem_req_wdata, m_wdata);
         end
         chk1("rnd_inst_rsp", inst_rsp_valid, e_ipulse);
         chk1("rnd_data_rsp", data_rsp_valid, e_dpulse);
         chk32("rnd_inst_rdata", inst_rsp_rdata, e_irdata);
         chk32("rnd_data_rdata", data_rsp_rdata, e_drdata);

         e_ipulse = 0;
         e_dpulse = 0;
         if (!m_busy) begin
            if (data_req_valid && e_da) begin
               m_busy = 1; m_sent = 0; m_cancel = 0; m_own_data = 1;
               m_wr = data_req_wr; m_addr = data_req_addr;
               m_wdata = data_req_wdata; m_wstrb = data_req_wstrb;
               if (inst_req_valid && m_starve < STARVE_MAX) m_starve++;
            end else if (inst_req_valid && e_ia) begin
               m_busy = 1; m_sent = 0; m_cancel = 0; m_own_data = 0;
               m_wr = 0; m_addr = inst_req_addr; m_wdata = '0; m_wstrb = '0;
               m_starve = 0;
            end
         end else if (!m_sent) begin
            if (!m_own_data && inst_flush) m_cancel = 1;
            if (mem_req_ready) begin
               m_sent   = 1;
               rsp_wait = $urandom_range(0, 3);
               if (m_wr) begin
                  v = mem_rd(m_addr);
                  for (int b = 0; b < 4; b++) begin
                     if (m_wstrb[b]) v[8*b +: 8] = m_wdata[8*b +: 8];
                  end
                  mem[m_addr] = v;
               end
            end
         end else begin
            if (!m_own_data && inst_flush) m_cancel = 1;
            if (mem_rsp_valid) begin
               m_busy = 0;
               if (m_own_data) begin
                  e_dpulse = 1;
                  e_drdata = m_wr ? 32'h0 : mem_rsp_rdata;
               end else if (!m_cancel) begin
                  e_ipulse = 1;
                  e_irdata = mem_rsp_rdata;
               end
            end else begin
               rsp_wait--;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-outstanding memory port between the instruction-fetch stage (inst side) and the memory-access stage (data side).
- Each requester connects through the pipeline valid/allowin handshake. The memory side uses a valid/ready request channel and a valid-only response channel.
- The data side has fixed priority. An anti-starvation counter guarantees that fetch progresses. An inst-side flush cancels the in-flight fetch response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive lost arbitrations after which the inst side wins once (1..15)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
inst_req_valid  in  1  fetch request present
inst_req_addr  in  ADDR_W  fetch address
inst_req_allowin  out  1  arbiter accepts the inst request this cycle
inst_flush  in  1  pipeline flush pulse; cancels the pending fetch response
inst_rsp_valid  out  1  one-cycle pulse; fetch data valid
inst_rsp_rdata  out  DATA_W  fetch data
data_req_valid  in  1  load/store request present
data_req_wr  in  1  1 = store
data_req_addr  in  ADDR_W  address
data_req_wdata  in  DATA_W  store data
data_req_wstrb  in  DATA_W/8  byte strobes
data_req_allowin  out  1  arbiter accepts the data request this cycle
data_rsp_valid  out  1  one-cycle pulse; load data, or store acknowledge
data_rsp_rdata  out  DATA_W  load data (0 for stores)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_req_wr  out  1  write
mem_req_addr  out  ADDR_W  address
mem_req_wdata  out  DATA_W  write data
mem_req_wstrb  out  DATA_W/8  strobes (0 for inst reads)
mem_rsp_valid  in  1  memory response pulse
mem_rsp_rdata  in  DATA_W  response data

Behaviour:
- FSM states: IDLE, REQ, WAIT. The state plus registered owner, cancel and payload are all cleared by reset.
- Reset values: every output is 0, state = IDLE, starve_cnt = 0.
- Reset asserted mid-transaction:
  - The transaction is abandoned.
  - The memory is reset with the arbiter, so no stale response is expected.
- IDLE, request acceptance:
  - data_req_allowin = data_req_valid-independent idle flag: 1 in IDLE, unless the inst side is forced by starvation.
  - inst_req_allowin = IDLE & !inst_flush & (!data_req_valid | starve_cnt == STARVE_MAX).
  - Exactly one side is accepted per cycle.
- Grant in cycle T:
  - At T+1: payload and owner are registered, state = REQ, mem_req_valid = 1.
  - Payload, valid and owner are held stable until mem_req_ready.
- REQ to WAIT: when mem_req_valid & mem_req_ready, the FSM moves to WAIT and mem_req_valid drops on the next cycle.
  - The request is never retracted once mem_req_valid is high, even on a flush.
- WAIT to IDLE: on mem_rsp_valid at cycle R, data is registered.
  - At R+1 the owner's rsp_valid pulses for one cycle and state = IDLE.
  - A new grant is possible at R+1, so the next mem_req_valid appears at R+2.
- Cancel:
  - inst_flush while the owner is inst in REQ or WAIT sets the cancel bit.
  - A flush arriving in the same cycle as mem_rsp_valid also sets cancel.
  - With cancel set, the response is consumed but inst_rsp_valid stays 0. Cancel clears on return to IDLE.
  - inst_flush has no effect on a data-owned transaction.
- Starvation counter (starve_cnt):
  - Increments (saturating at STARVE_MAX) when a data grant occurs while inst_req_valid = 1.
  - Resets to 0 on any inst grant.
  - At STARVE_MAX the inst side wins even if data_req_valid = 1.
- Store responses: data_rsp_valid pulses with data_rsp_rdata = 0.
- Outputs: rsp_rdata is registered; it holds its last value when rsp_valid = 0.
- mem_rsp_valid outside WAIT is ignored. This is a protocol error; add an assertion in simulation only.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/REQ/WAIT)
  - Owner encoding (OWN_INST = 0, OWN_DATA = 1)
  - Request payload struct {wr, addr, wdata, wstrb}
- No sub-module needed. The grant logic, including the starvation counter, may be split out as mem_port_grant if it grows.

Test Plan:
1. Inst only, addr 0x1000_0000, mem ready at once, rsp 2 cycles later with 0xDEADBEEF -> grant T, mem_req_valid T+1, inst_rsp_valid at rsp+1 with 0xDEADBEEF, data side silent.
2. Both valid in the same IDLE cycle, data store 0x20 (wdata 0x55AA, wstrb 0x3) -> data granted first with wr = 1, wstrb = 0x3; data_rsp_valid with rdata 0; inst granted at the next IDLE.
3. Starvation, STARVE_MAX = 4, data_req_valid and inst_req_valid held high -> four data grants, then the fifth grant goes to inst; starve_cnt returns to 0.
4. Flush during WAIT on an inst fetch -> mem transaction completes, inst_rsp_valid stays 0, next request accepted at rsp+1.
5. Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid, addr and data stable all 5 cycles; both allowins are 0.
6. rst driven low mid-WAIT (async, between clock edges) -> all outputs 0 immediately; after release, state is IDLE and a fresh inst request works as in scenario 1.
